// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_pkg
// Purpose  : Shared state encoding and default widths for the MAC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } mac_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_ctrl
// Purpose  : Drives an external MAC through a dot-product job (clear, stream,
//            drain, present). Optional overflow tracking: MAC_SEQ_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int LEN_MAX = 8,
  parameter int MAC_LAT = 1,
  parameter int CNT_W   = $clog2(LEN_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              err_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mac_en,
  output logic              mac_clr,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_cout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf
);

  localparam int               DRN_W     = $clog2(MAC_LAT + 2);
  localparam logic [CNT_W-1:0] c_len_max = CNT_W'(LEN_MAX);
  localparam logic [DRN_W-1:0] c_drn_end = DRN_W'(MAC_LAT);

  mac_seq_state_t    r_state;
  mac_seq_state_t    w_next;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic [DRN_W-1:0]  r_drain;
  logic              r_mac_en;
  logic              r_mac_clr;
  logic [DATA_W-1:0] r_mac_a;
  logic [DATA_W-1:0] r_mac_b;
  logic              r_err_len;
  logic [ACC_W-1:0]  r_res_data;

  logic w_start_ok;
  logic w_in_hs;
  logic w_last;
  logic w_drain_done;

  assign w_start_ok   = (len != '0) && (len <= c_len_max);
  assign w_in_hs      = (r_state == RUN) && in_valid;
  assign w_last       = w_in_hs && (r_cnt == (r_len - CNT_W'(1)));
  assign w_drain_done = (r_state == DRAIN) && (r_drain == c_drn_end);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start && w_start_ok) w_next = CLEAR;
        CLEAR:   w_next = RUN;
        RUN:     if (w_last) w_next = DRAIN;
        DRAIN:   if (w_drain_done) w_next = DONE;
        DONE:    if (res_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy      = (r_state != IDLE);
    in_ready  = (r_state == RUN);
    res_valid = (r_state == DONE);
  end

  // Registered MAC controls, pair counter, drain timer and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_drain    <= '0;
      r_mac_en   <= 1'b0;
      r_mac_clr  <= 1'b0;
      r_mac_a    <= '0;
      r_mac_b    <= '0;
      r_err_len  <= 1'b0;
      r_res_data <= '0;
    end else begin
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
      r_err_len <= 1'b0;
      if (abort) begin
        r_cnt     <= '0;
        r_mac_clr <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (w_start_ok) begin
                r_len     <= len;
                r_cnt     <= '0;
                r_mac_clr <= 1'b1;
              end else begin
                r_err_len <= 1'b1;
              end
            end
          end
          RUN: begin
            r_drain <= '0;
            if (w_in_hs) begin
              r_mac_a  <= in_a;
              r_mac_b  <= in_b;
              r_mac_en <= 1'b1;
              r_cnt    <= r_cnt + CNT_W'(1);
            end
          end
          DRAIN: begin
            if (w_drain_done) begin
              r_res_data <= mac_cout;
            end else begin
              r_drain <= r_drain + DRN_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign mac_en   = r_mac_en;
  assign mac_clr  = r_mac_clr;
  assign mac_a    = r_mac_a;
  assign mac_b    = r_mac_b;
  assign err_len  = r_err_len;
  assign res_data = r_res_data;

`ifdef MAC_SEQ_OVF_EN
  logic [ACC_W-1:0] r_prev;
  logic             r_ovf_sticky;
  logic             r_res_ovf;
  logic             w_track;
  logic             w_ovf_now;

  // Products are non-negative, so any decrease of the accumulator is a wrap
  assign w_track   = (r_state == RUN) || (r_state == DRAIN);
  assign w_ovf_now = w_track && (mac_cout < r_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev       <= '0;
      r_ovf_sticky <= 1'b0;
      r_res_ovf    <= 1'b0;
    end else begin
      if (r_state == CLEAR) begin
        r_prev       <= '0;
        r_ovf_sticky <= 1'b0;
      end else if (w_track) begin
        r_prev <= mac_cout;
        if (w_ovf_now) r_ovf_sticky <= 1'b1;
      end
      // The final accumulation can wrap in the capture cycle itself
      if (w_drain_done && !abort) r_res_ovf <= r_ovf_sticky | w_ovf_now;
    end
  end

  assign res_ovf = r_res_ovf;
`else
  assign res_ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// Bench for mac_seq_ctrl: behavioural MAC model, directed jobs, result
// scoreboard checked by an independent monitor.
module tb_mac_seq_ctrl;
  import mac_seq_pkg::*;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 16;
  localparam int LEN_MAX = 8;
  localparam int MAC_LAT = 1;
  localparam int CNT_W   = $clog2(LEN_MAX + 1);
`ifdef MAC_SEQ_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic res_ready = 1'b1;
  logic [CNT_W-1:0]  len = '0;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic busy, err_len, in_ready, mac_en, mac_clr, res_valid, res_ovf;
  logic [DATA_W-1:0] mac_a, mac_b;
  logic [ACC_W-1:0]  mac_cout, res_data;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int clr_cnt = 0;
  int err_cnt = 0;
  int c0, e0;
  logic hold_v = 1'b0;
  logic [ACC_W-1:0] hold_d = '0;

  mac_seq_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_MAX(LEN_MAX), .MAC_LAT(MAC_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .busy(busy), .err_len(err_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_a(mac_a), .mac_b(mac_b), .mac_cout(mac_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  // External MAC with one cycle of latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mac_cout <= '0;
    else if (mac_clr) mac_cout <= '0;
    else if (mac_en)  mac_cout <= mac_cout + ACC_W'(mac_a) * ACC_W'(mac_b);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_clr) clr_cnt++;
      if (err_len) err_cnt++;
      if (mac_clr) check("clr_en_overlap", mac_en, 0);
      if (hold_v && res_valid) check("res_stable", res_data, hold_d);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", res_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_data", res_data, mon_e.data);
          check("res_ovf", res_ovf, mon_e.ovf);
        end
      end
      hold_v = res_valid && !res_ready;
      hold_d = res_data;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = CNT_W'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input int a, input int b, input int gap);
    int k = 0;
    in_valid = 1'b1;
    in_a = DATA_W'(a);
    in_b = DATA_W'(b);
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!res_valid && k < 50) begin
      tick();
      k++;
    end
    if (!res_valid) check("valid_timeout", res_valid, 1);
  endtask

  task automatic wait_result();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      check("result_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, {busy, err_len, in_ready, mac_en, mac_clr, res_valid, res_ovf}, 0);
    check({tag, "_data"}, {mac_a, mac_b, res_data}, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic job: 1*2 + 3*4 + 5*6 = 44
    exp_q.push_back({ACC_W'(44), 1'b0});
    do_start(3);
    check("clr_in_clear", mac_clr, 1);
    check("busy_job", busy, 1);
    send_pair(1, 2, 0);
    send_pair(3, 4, 0);
    send_pair(5, 6, 0);
    wait_result();
    check("busy_after_job", busy, 0);

    // Length errors
    c0 = clr_cnt;
    e0 = err_cnt;
    do_start(0);
    check("err_len0", err_len, 1);
    check("idle_len0", busy, 0);
    tick();
    check("err_len0_single", err_len, 0);
    do_start(9);
    check("err_len9", err_len, 1);
    check("idle_len9", busy, 0);
    tick();
    check("err_pulse_count", err_cnt - e0, 2);
    check("no_clr_on_err", clr_cnt - c0, 0);

    // Stalls and backpressure: 255*255 + 2*3 = 65031
    res_ready = 1'b0;
    exp_q.push_back({ACC_W'(65031), 1'b0});
    do_start(2);
    send_pair(255, 255, 3);
    send_pair(2, 3, 0);
    wait_valid();
    repeat (5) tick();
    check("valid_held", res_valid, 1);
    res_ready = 1'b1;
    wait_result();
    check("busy_after_bp", busy, 0);

    // Abort after 2 of 4 pairs, with a simultaneous offered pair
    do_start(4);
    send_pair(1, 1, 0);
    send_pair(2, 2, 0);
    in_valid = 1'b1;
    in_a = 8'd9;
    in_b = 8'd9;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_clr", mac_clr, 1);
    check("abort_no_en", mac_en, 0);
    check("abort_idle", busy, 0);
    tick();
    check("abort_clr_once", mac_clr, 0);

    // Minimum-latency job after abort: 7*7 = 49, valid 5 cycles after start
    exp_q.push_back({ACC_W'(49), 1'b0});
    do_start(1);
    send_pair(7, 7, 0);
    tick();
    check("lat_cycle4", res_valid, 0);
    tick();
    check("lat_cycle5", res_valid, 1);
    wait_result();

    // Accumulator wrap: 2*65025 mod 2^16 = 64514
    exp_q.push_back({ACC_W'(64514), OVF_EXP});
    do_start(2);
    send_pair(255, 255, 0);
    send_pair(255, 255, 0);
    wait_result();

    // Reset during DRAIN discards the job
    do_start(1);
    send_pair(4, 4, 0);
    check("busy_drain", busy, 1);
    rst_n = 1'b0;
    #1 check_reset_values("reset_drain");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", {busy, res_valid}, 0);

    // start during RUN is ignored: 10*20 + 3*3 = 209
    exp_q.push_back({ACC_W'(209), 1'b0});
    e0 = err_cnt;
    do_start(2);
    send_pair(10, 20, 0);
    start = 1'b1;
    len = CNT_W'(5);
    tick();
    start = 1'b0;
    check("start_ignored_busy", busy, 1);
    send_pair(3, 3, 0);
    wait_result();
    check("busy_after_ignored", busy, 0);
    check("no_err_in_run", err_cnt - e0, 0);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
